// File: rtl/fifo_stream_out.sv
// fifo_stream_out: drains a one-cycle-latency FIFO read port into a valid/ready stream.
// Frame marking on m_last is compiled in when FIFO_STREAM_OUT_LAST_EN is defined.
module fifo_stream_out #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  rd_ena,
  input  logic [DATA_WIDTH-1:0] rd_dat,
  input  logic                  rd_empty,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
`ifdef FIFO_STREAM_OUT_LAST_EN
  ,
  output logic                  m_last
`endif
);

  if (FRAME_LEN < 1) begin : g_bad_frame_len
    $error("fifo_stream_out: FRAME_LEN must be at least 1");
  end

  logic [DATA_WIDTH-1:0] buf_mem [2];
  logic [1:0]            cnt;
  logic                  inflight;
  logic                  head;
  logic                  tail;
  logic                  pop;
  logic [2:0]            occ_after_pop;

  assign m_valid = (cnt != 2'd0);
  assign m_data  = buf_mem[head];
  assign pop     = m_valid & m_ready;

  // Occupancy counts words already buffered plus the one returning from the FIFO,
  // minus the beat leaving this cycle; a new pop is issued only if a slot remains.
  // NOTE: every output of an always_comb is assigned on every path, so no latch is inferred.
  always_comb begin
    occ_after_pop = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
    rd_ena        = rst && !rd_empty && (occ_after_pop < 3'd2);
  end

  // NOTE: the two buffer entries are reset like any register so m_data reads 0 out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      cnt        <= 2'd0;
      inflight   <= 1'b0;
      head       <= 1'b0;
      tail       <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every term reads pre-edge values.
      inflight <= rd_ena;
      if (inflight) begin
        buf_mem[tail] <= rd_dat;
        tail          <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      cnt <= cnt + {1'b0, inflight} - {1'b0, pop};
    end
  end

  a_cnt_bound : assert property (@(posedge clk) disable iff (!rst) cnt <= 2'd2);

`ifdef FIFO_STREAM_OUT_LAST_EN
  localparam int            IDX_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic [IDX_W-1:0] beat_idx;
  logic             at_last;

  assign at_last = (beat_idx == LAST_IDX);
  assign m_last  = m_valid && at_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_idx <= '0;
    end else if (pop) begin
      beat_idx <= at_last ? '0 : beat_idx + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_out.sv
// Directed bench for fifo_stream_out: two instances (FRAME_LEN 16 and 4), each fed by a
// behavioural one-cycle-latency FIFO; m_last checks exist only with FIFO_STREAM_OUT_LAST_EN.
module tb_fifo_stream_out;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic          rd_ena0, rd_empty0, m_valid0, m_ready0;
  logic [DW-1:0] rd_dat0, m_data0;
  logic          rd_ena1, rd_empty1, m_valid1, m_ready1;
  logic [DW-1:0] rd_dat1, m_data1;
`ifdef FIFO_STREAM_OUT_LAST_EN
  logic          m_last0, m_last1;
`endif

  logic [DW-1:0] mem0 [256];
  logic [DW-1:0] mem1 [256];
  logic [7:0]    wp0 = '0, rp0 = '0;
  logic [7:0]    wp1 = '0, rp1 = '0;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_idx;

  always #5 clk = ~clk;

  fifo_stream_out #(.DATA_WIDTH(DW), .FRAME_LEN(16)) u_dut0 (
    .clk      (clk),
    .rst      (rst),
    .rd_ena   (rd_ena0),
    .rd_dat   (rd_dat0),
    .rd_empty (rd_empty0),
    .m_valid  (m_valid0),
    .m_data   (m_data0),
    .m_ready  (m_ready0)
`ifdef FIFO_STREAM_OUT_LAST_EN
    ,
    .m_last   (m_last0)
`endif
  );

  fifo_stream_out #(.DATA_WIDTH(DW), .FRAME_LEN(4)) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .rd_ena   (rd_ena1),
    .rd_dat   (rd_dat1),
    .rd_empty (rd_empty1),
    .m_valid  (m_valid1),
    .m_data   (m_data1),
    .m_ready  (m_ready1)
`ifdef FIFO_STREAM_OUT_LAST_EN
    ,
    .m_last   (m_last1)
`endif
  );

  // FIFO models: data appears the cycle after a pop; reset empties the queue.
  assign rd_empty0 = (wp0 == rp0);
  assign rd_empty1 = (wp1 == rp1);

  always @(posedge clk or negedge rst) begin
    if (!rst) rp0 <= wp0;
    else if (rd_ena0) begin
      rd_dat0 <= mem0[rp0];
      rp0     <= rp0 + 8'd1;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) rp1 <= wp1;
    else if (rd_ena1) begin
      rd_dat1 <= mem1[rp1];
      rp1     <= rp1 + 8'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push0(input logic [DW-1:0] v);
    mem0[wp0] = v;
    wp0 = wp0 + 8'd1;
  endtask

  task automatic push1(input logic [DW-1:0] v);
    mem1[wp1] = v;
    wp1 = wp1 + 8'd1;
  endtask

  // Edge monitor: pre-edge values are sampled; a stalled beat must not change.
  logic          hold0 = 1'b0;
  logic [DW-1:0] held0 = '0;
  always @(posedge clk) begin
    if (!rst) begin
      hold0 <= 1'b0;
    end else begin
      check("pop_while_empty0", 32'(rd_ena0 & rd_empty0), 0);
      check("pop_while_empty1", 32'(rd_ena1 & rd_empty1), 0);
      if (hold0) begin
        check("stall_valid", 32'(m_valid0), 1);
        check("stall_data", 32'(m_data0), 32'(held0));
      end
      hold0 <= m_valid0 & ~m_ready0;
      held0 <= m_data0;
    end
  end

  initial begin
    m_ready0 = 1'b0;
    m_ready1 = 1'b0;

    // Reset and idle
    repeat (3) @(negedge clk);
    check("rst_rd_ena", 32'(rd_ena0), 0);
    check("rst_m_valid", 32'(m_valid0), 0);
    check("rst_m_data", 32'(m_data0), 0);
`ifdef FIFO_STREAM_OUT_LAST_EN
    check("rst_m_last", 32'(m_last0), 0);
`endif
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_rd_ena", 32'(rd_ena0), 0);
      check("idle_m_valid", 32'(m_valid0), 0);
`ifdef FIFO_STREAM_OUT_LAST_EN
      check("idle_m_last", 32'(m_last0), 0);
`endif
    end

    // First-word latency
    m_ready0 = 1'b1;
    push0(8'd5);
    #1;
    check("lat_rd_ena_t0", 32'(rd_ena0), 1);
    @(negedge clk);
    check("lat_rd_ena_t1", 32'(rd_ena0), 0);
    check("lat_valid_t1", 32'(m_valid0), 0);
    @(negedge clk);
    check("lat_valid_t2", 32'(m_valid0), 1);
    check("lat_data_t2", 32'(m_data0), 5);
`ifdef FIFO_STREAM_OUT_LAST_EN
    check("lat_last_t2", 32'(m_last0), 0);
`endif
    @(negedge clk);
    check("lat_valid_t3", 32'(m_valid0), 0);
    check("lat_rd_ena_t3", 32'(rd_ena0), 0);

    // Short reset so the frame counter starts from beat 0
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Throughput: 16 back-to-back beats
    for (int k = 0; k < 16; k++) push0(8'(k));
    #1;
    check("thr_rd_ena", 32'(rd_ena0), 1);
    @(negedge clk);
    check("thr_valid_pre", 32'(m_valid0), 0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("thr_valid", 32'(m_valid0), 1);
      check("thr_data", 32'(m_data0), k);
`ifdef FIFO_STREAM_OUT_LAST_EN
      check("thr_last", 32'(m_last0), 32'(k == 15));
`endif
    end
    @(negedge clk);
    check("thr_valid_post", 32'(m_valid0), 0);

    // Frame wrap on the FRAME_LEN=4 instance
    m_ready1 = 1'b1;
    for (int k = 0; k < 10; k++) push1(8'(8'h40 + k));
    @(negedge clk);
    check("wrap_valid_pre", 32'(m_valid1), 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("wrap_valid", 32'(m_valid1), 1);
      check("wrap_data", 32'(m_data1), 32'(8'h40 + k));
`ifdef FIFO_STREAM_OUT_LAST_EN
      check("wrap_last", 32'(m_last1), 32'(k == 3 || k == 7));
`endif
    end
    @(negedge clk);
    check("wrap_valid_post", 32'(m_valid1), 0);
    push1(8'h50);
    push1(8'h51);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("wrap_tail_data", 32'(m_data1), 32'(8'h50 + k));
`ifdef FIFO_STREAM_OUT_LAST_EN
      check("wrap_tail_last", 32'(m_last1), 32'(k == 1));
`endif
    end

    // Backpressure: fill two slots, then m_ready pattern 1,0,0 repeating
    m_ready0 = 1'b0;
    for (int k = 0; k < 10; k++) push0(8'(k));
    #1;
    check("bp_rd_ena_t0", 32'(rd_ena0), 1);
    @(negedge clk);
    check("bp_rd_ena_t1", 32'(rd_ena0), 1);
    check("bp_valid_t1", 32'(m_valid0), 0);
    @(negedge clk);
    check("bp_rd_ena_t2", 32'(rd_ena0), 0);
    check("bp_valid_t2", 32'(m_valid0), 1);
    check("bp_data_t2", 32'(m_data0), 0);
    @(negedge clk);
    check("bp_rd_ena_full", 32'(rd_ena0), 0);
    check("bp_data_full", 32'(m_data0), 0);
    m_ready0 = 1'b1;
    #1;
    check("bp_rd_ena_resume", 32'(rd_ena0), 1);
    check("bp_data_first", 32'(m_data0), 0);
    exp_idx = 1;
    for (int i = 1; i < 60 && exp_idx < 10; i++) begin
      @(negedge clk);
      m_ready0 = (i % 3 == 0);
      #1;
      if (m_valid0 && m_ready0) begin
        check("bp_data", 32'(m_data0), exp_idx);
        exp_idx++;
      end
    end
    check("bp_beats", exp_idx, 10);
    @(negedge clk);
    check("bp_valid_post", 32'(m_valid0), 0);

    // Reset mid-stream with one word buffered and one in flight
    m_ready0 = 1'b0;
    push0(8'h11);
    push0(8'h22);
    push0(8'h33);
    @(negedge clk);
    @(negedge clk);
    check("mid_valid_pre", 32'(m_valid0), 1);
    check("mid_data_pre", 32'(m_data0), 32'h11);
    rst = 1'b0;
    #1;
    check("mid_valid_rst", 32'(m_valid0), 0);
    check("mid_data_rst", 32'(m_data0), 0);
    check("mid_rd_ena_rst", 32'(rd_ena0), 0);
    @(negedge clk);
    rst = 1'b1;
    m_ready0 = 1'b1;
    for (int k = 0; k < 16; k++) push0(8'(7 + k));
    #1;
    check("mid_rd_ena_restart", 32'(rd_ena0), 1);
    @(negedge clk);
    check("mid_valid_pre2", 32'(m_valid0), 0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("mid_valid", 32'(m_valid0), 1);
      check("mid_data", 32'(m_data0), 7 + k);
`ifdef FIFO_STREAM_OUT_LAST_EN
      check("mid_last", 32'(m_last0), 32'(k == 15));
`endif
    end
    @(negedge clk);
    check("mid_valid_post", 32'(m_valid0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
